// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with bounded bursts and a baud divisor that only updates between frames.
// Optional per-requester accepted-byte counters are enabled by defining ARB_STATS_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned DIV_W     = 32,
    parameter int unsigned DIV_RESET = 651
) (
    input  logic                        clk,
    input  logic                        areset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic [DATA_W-1:0]           uart_tx_data,
    output logic                        uart_tx_start,
    input  logic                        uart_tx_busy,
    input  logic                        cfg_div_wr,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic [DIV_W-1:0]            divisor,
    output logic                        div_pending
`ifdef ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0]  stat_sel,
    output logic [15:0]                 stat_count
`endif
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state, state_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic [IDX_W-1:0]     gidx, gidx_d;
    logic [IDX_W-1:0]     ptr, ptr_d;
    logic [IDX_W-1:0]     pick, next_ptr;
    logic                 pick_vld;
    logic [BURST_W-1:0]   burst, burst_d, burst_inc;
    logic [DATA_W-1:0]    tx_data_d;
    logic                 tx_start_d;
    logic [DIV_W-1:0]     divisor_d;
    logic [DIV_W-1:0]     shadow, shadow_d;
    logic                 div_pending_d;
    logic                 gvalid;
    logic [DATA_W-1:0]    gdata;

    // First requesting index at or above the rr pointer, with wrap
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && req_valid[IDX_W'((32'(ptr) + i) % NUM_REQ)]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'((32'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gvalid    = req_valid[gidx];
        gdata     = req_data[32'(gidx) * DATA_W +: DATA_W];
        next_ptr  = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
        burst_inc = burst + BURST_W'(1);
        req_ready = (state == LOAD) ? (grant & {NUM_REQ{gvalid}}) : '0;
    end

    always_comb begin
        state_d       = state;
        grant_d       = grant;
        gidx_d        = gidx;
        ptr_d         = ptr;
        burst_d       = burst;
        tx_data_d     = uart_tx_data;
        tx_start_d    = 1'b0;
        divisor_d     = divisor;
        shadow_d      = shadow;
        div_pending_d = div_pending;

        case (state)
            IDLE: begin
                // A pending divisor wins over new grants so it lands on an idle line
                if (div_pending && !uart_tx_busy) begin
                    divisor_d     = shadow;
                    div_pending_d = 1'b0;
                end else if (pick_vld && !uart_tx_busy) begin
                    grant_d = NUM_REQ'(1) << pick;
                    gidx_d  = pick;
                    burst_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (gvalid) begin
                    tx_data_d  = gdata;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_BUSY;
                end else begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    burst_d = burst_inc;
                    if (burst_inc == BURST_W'(MAX_BURST) || !gvalid || div_pending) begin
                        grant_d = '0;
                        ptr_d   = next_ptr;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Writes after the apply decision so a same-cycle write stays pending
        if (cfg_div_wr && (cfg_div != '0)) begin
            shadow_d      = cfg_div;
            div_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state         <= IDLE;
            grant         <= '0;
            gidx          <= '0;
            ptr           <= '0;
            burst         <= '0;
            uart_tx_data  <= '0;
            uart_tx_start <= 1'b0;
            divisor       <= DIV_W'(DIV_RESET);
            shadow        <= '0;
            div_pending   <= 1'b0;
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            gidx          <= gidx_d;
            ptr           <= ptr_d;
            burst         <= burst_d;
            uart_tx_data  <= tx_data_d;
            uart_tx_start <= tx_start_d;
            divisor       <= divisor_d;
            shadow        <= shadow_d;
            div_pending   <= div_pending_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_REQ];

    // Saturating accepted-byte counters
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i] && (stat_cnt[i] != 16'hFFFF)) begin
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (tx_data/start/busy side of the uart block) between NUM_REQ byte requesters.
- Uses round-robin grants with bounded bursts.
- Owns the UART baud divisor register, so divisor updates only land between bytes and never corrupt a frame in flight.
- Sits between the application byte sources and one uart instance, in that instance's clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width
- MAX_BURST, 4, max consecutive bytes per grant (1..15)
- DIV_W, 32, divisor width
- DIV_RESET, 651, divisor after reset (9600 baud at 10 ns clock, x16 oversample)

Ports:
- clk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  byte accepted this cycle (combinational, one-hot or zero)
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- uart_tx_data  out  DATA_W  byte to UART
- uart_tx_start  out  1  one-cycle start pulse to UART
- uart_tx_busy  in  1  UART frame in progress
- cfg_div_wr  in  1  divisor write strobe
- cfg_div  in  DIV_W  new divisor value
- divisor  out  DIV_W  divisor driven to UART
- div_pending  out  1  write captured, not yet applied

Behaviour:
- Interface: one clock, clk. Reset areset_n is asynchronous and active-low; assertion forces all state immediately, independent of clk.
- Reset values:
  - grant=0, uart_tx_start=0, uart_tx_data=0, req_ready=0
  - divisor=DIV_RESET, div_pending=0, shadow divisor cleared
  - rr pointer=0, burst count=0, state=IDLE
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If div_pending and uart_tx_busy=0: divisor<=shadow, div_pending<=0; no grant that cycle.
  - Else if any req_valid and uart_tx_busy=0: pick the first set bit scanning from the rr pointer upward with wrap; grant<=onehot, burst<=0, go LOAD.
- LOAD:
  - req_ready[g]=req_valid[g] (combinational).
  - If req_valid[g]=1: uart_tx_data<=req_data[g], uart_tx_start<=1 for exactly one cycle, go WAIT_BUSY.
  - If req_valid[g]=0: grant<=0, ptr<=(g+1) mod NUM_REQ, go IDLE.
- WAIT_BUSY: stay until uart_tx_busy=1, then go WAIT_DONE. uart_tx_start is already low again.
- WAIT_DONE: on uart_tx_busy=0, burst<=burst+1. Release if burst+1==MAX_BURST, or req_valid[g]=0, or div_pending=1:
  - Release: grant<=0, ptr<=(g+1) mod NUM_REQ, go IDLE.
  - Otherwise: go LOAD.
- Latency: req_valid high in IDLE at edge 0 → grant from edge 0 → req_ready high in the following cycle → uart_tx_start high in the cycle after edge 1.
- Per-byte overhead beyond the UART frame: 2 cycles (LOAD, start-to-busy).
- Divisor config:
  - cfg_div_wr with cfg_div!=0: shadow<=cfg_div, div_pending<=1.
  - cfg_div==0: write ignored.
  - A second write before apply overwrites the shadow.
  - A write in the same cycle as apply: the new value goes to the shadow and div_pending stays 1.
- Pending divisor gets priority over new grants in IDLE and forces early release of a burst.
- grant never changes while state is WAIT_BUSY or WAIT_DONE.
- req_ready never asserts outside LOAD.
- Reset mid-frame: outputs return to reset values at once; the pending shadow is lost; the UART is reset by the same system reset.

Optional Feature:
- ARB_STATS_EN defined: adds ports stat_sel (in, $clog2(NUM_REQ)) and stat_count (out, 16).
  - One 16-bit saturating counter per requester, incremented on each accepted byte (req_ready&req_valid).
  - stat_count=counter[stat_sel], combinational; counters clear on reset.
  - Saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single source: reset, req_valid[1]=1 with data 8'hA5, busy modelled 3 cycles after start → uart_tx_start one cycle, uart_tx_data=8'hA5, grant=4'b0010, req_ready[1] one cycle.
- Fairness: all four req_valid held, MAX_BURST=4 → UART byte order is 4 bytes from 0, 4 from 1, 4 from 2, 4 from 3, then 0 again.
- Early release: req 2 drops after 2 bytes while req 3 is pending → grant moves to 4'b1000 after the 2nd frame; the 3rd byte from req 2 is not taken.
- Divisor: cfg_div_wr with 326 mid-frame → divisor stays 651 until busy falls, burst is released, then divisor=326 and div_pending=0; a write of 0 leaves divisor unchanged.
- Reset mid-frame: drop areset_n during WAIT_DONE → grant=0, uart_tx_start=0, divisor=651 immediately; after release, arbitration restarts at requester 0.
- ARB_STATS_EN: 5 bytes from req 0 and 2 from req 3 → stat_count reads 5 and 2 for stat_sel 0 and 3, and 0 for the others.
